// File: rtl/conv_tap_sequencer.sv
// -----------------------------------------------------------------------------
// conv_tap_sequencer
//
// Frame scheduler for the convolution MAC datapath. For every output position
// of the feature map it walks the KSIZE x KSIZE kernel taps (stalling whenever
// the window stage has no data), drives the MAC clear/enable/last strobes,
// waits MAC_LAT cycles for the accumulator to settle, then offers one output
// handshake. A one-cycle done pulse follows the last handshake of the frame.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   start_i      frame start pulse, honoured only in IDLE
//   win_valid_i  window data for the current tap is present
//   out_ready_i  downstream accepts the result
//   busy_o       high in TAP, DRAIN and OUTPUT
//   done_o       one-cycle pulse after the last output handshake
//   tap_row_o    kernel row of the current tap
//   tap_col_o    kernel column of the current tap
//   mac_en_o     MAC accumulate enable (combinational on win_valid_i)
//   mac_clr_o    clear accumulator, asserted with tap (0,0)
//   mac_last_o   final tap of the position
//   out_valid_o  result for (out_x_o, out_y_o) is valid
//   out_x_o      current output column
//   out_y_o      current output row
//   stall_cnt_o  (only with CONV_TAP_SEQ_STALL_CNT_EN) saturating count of
//                window stalls in TAP plus backpressure cycles in OUTPUT
//
// Optional build macro: CONV_TAP_SEQ_STALL_CNT_EN
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; taps, drain count and position cleared
// TAP     | stepping kernel taps, one per cycle with win_valid_i
// DRAIN   | waiting MAC_LAT cycles for the accumulator result
// OUTPUT  | presenting result, holding position until out_ready_i
// DONE    | one-cycle frame-complete pulse
// -----------------------------------------------------------------------------
module conv_tap_sequencer #(
  parameter int KSIZE   = 3,
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int MAC_LAT = 2,
  localparam int OUT_W  = IMG_W - KSIZE + 1,
  localparam int OUT_H  = IMG_H - KSIZE + 1,
  localparam int KW     = (KSIZE > 1) ? $clog2(KSIZE) : 1,
  localparam int XW     = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int YW     = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          win_valid_i,
  input  logic          out_ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [KW-1:0] tap_row_o,
  output logic [KW-1:0] tap_col_o,
  output logic          mac_en_o,
  output logic          mac_clr_o,
  output logic          mac_last_o,
  output logic          out_valid_o,
  output logic [XW-1:0] out_x_o,
  output logic [YW-1:0] out_y_o
`ifdef CONV_TAP_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt_o
`endif
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(KSIZE - 1);
  localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);
  localparam logic [DW-1:0] D_LAST = DW'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TAP    = 3'd1,
    S_DRAIN  = 3'd2,
    S_OUTPUT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q,   state_d;
  logic [KW-1:0] tap_row_q, tap_row_d;
  logic [KW-1:0] tap_col_q, tap_col_d;
  logic [DW-1:0] drain_q,   drain_d;
  logic [XW-1:0] out_x_q,   out_x_d;
  logic [YW-1:0] out_y_q,   out_y_d;

  logic tap_first;
  logic tap_last;

  assign tap_first = (tap_row_q == '0)     && (tap_col_q == '0);
  assign tap_last  = (tap_row_q == K_LAST) && (tap_col_q == K_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      tap_row_q <= '0;
      tap_col_q <= '0;
      drain_q   <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      tap_row_q <= tap_row_d;
      tap_col_q <= tap_col_d;
      drain_q   <= drain_d;
      out_x_q   <= out_x_d;
      out_y_q   <= out_y_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tap_row_d  = tap_row_q;
    tap_col_d  = tap_col_q;
    drain_d    = drain_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    mac_en_o   = 1'b0;
    mac_clr_o  = 1'b0;
    mac_last_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        tap_row_d = '0;
        tap_col_d = '0;
        drain_d   = '0;
        out_x_d   = '0;
        out_y_d   = '0;
        if (start_i) begin
          state_d = S_TAP;
        end
      end

      S_TAP: begin
        // The strobes follow win_valid_i in the same cycle so the MAC sees
        // enable alongside the window data it qualifies.
        if (win_valid_i) begin
          mac_en_o   = 1'b1;
          mac_clr_o  = tap_first;
          mac_last_o = tap_last;
          if (tap_last) begin
            tap_row_d = '0;
            tap_col_d = '0;
            state_d   = S_DRAIN;
          end else if (tap_col_q == K_LAST) begin
            tap_col_d = '0;
            tap_row_d = tap_row_q + KW'(1);
          end else begin
            tap_col_d = tap_col_q + KW'(1);
          end
        end
      end

      S_DRAIN: begin
        if (drain_q == D_LAST) begin
          drain_d = '0;
          state_d = S_OUTPUT;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end

      S_OUTPUT: begin
        if (out_ready_i) begin
          if ((out_x_q == X_LAST) && (out_y_q == Y_LAST)) begin
            state_d = S_DONE;
          end else if (out_x_q == X_LAST) begin
            out_x_d = '0;
            out_y_d = out_y_q + YW'(1);
            state_d = S_TAP;
          end else begin
            out_x_d = out_x_q + XW'(1);
            state_d = S_TAP;
          end
        end
      end

      S_DONE: begin
        // start_i is deliberately not looked at here; a new frame needs IDLE.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q == S_TAP) || (state_q == S_DRAIN) ||
                       (state_q == S_OUTPUT);
  assign done_o      = (state_q == S_DONE);
  assign out_valid_o = (state_q == S_OUTPUT);
  assign tap_row_o   = tap_row_q;
  assign tap_col_o   = tap_col_q;
  assign out_x_o     = out_x_q;
  assign out_y_o     = out_y_q;

`ifdef CONV_TAP_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_hit;

  assign stall_hit = ((state_q == S_TAP)    && !win_valid_i) ||
                     ((state_q == S_OUTPUT) && !out_ready_i);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_IDLE) && start_i) begin
      stall_cnt_d = '0;
    end else if (stall_hit && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
